// File: rtl/cam_access_pkg.sv
// cam_access_pkg
//   Shared types and constants for the CAM access controller slice.
//   - cam_state_e   : controller FSM states (also driven out on the debug port)
//   - WAIT_MIN      : minimum cycles spent in WAIT after a CAM write strobe
//   - res_rec_width : width of one result record {hit, match_addr}
package cam_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } cam_state_e;

    // BUSY from the CAM can rise a cycle after WE, so WAIT must not trust a
    // low BUSY in its first cycle.
    localparam int WAIT_MIN = 2;

    function automatic int res_rec_width(input int match_addr_width);
        return 1 + match_addr_width;
    endfunction

endpackage

// File: rtl/cam_access_ctrl_if.sv
// cam_access_ctrl_if
//   Update, lookup and result channels of the CAM access controller.
//   All three channels use the same handshake: a transfer happens on a rising
//   clock edge where valid and ready are both high; once valid is raised the
//   source holds valid and its payload stable until that transfer.
//   Ports (by channel):
//     upd_* : table update request (addr/data) from the control plane
//     lkp_* : lookup key from the data plane
//     res_* : lookup result (hit, match addr) back to the data plane
//   Modports: slave = controller side, master = requester side.
interface cam_access_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MADDR_W = 5
) ();
    logic               upd_valid;
    logic               upd_ready;
    logic [ADDR_W-1:0]  upd_addr;
    logic [DATA_W-1:0]  upd_data;

    logic               lkp_valid;
    logic               lkp_ready;
    logic [DATA_W-1:0]  lkp_key;

    logic               res_valid;
    logic               res_ready;
    logic               res_hit;
    logic [MADDR_W-1:0] res_addr;

    modport slave (
        input  upd_valid, upd_addr, upd_data,
        output upd_ready,
        input  lkp_valid, lkp_key,
        output lkp_ready,
        output res_valid, res_hit, res_addr,
        input  res_ready
    );

    modport master (
        output upd_valid, upd_addr, upd_data,
        input  upd_ready,
        output lkp_valid, lkp_key,
        input  lkp_ready,
        input  res_valid, res_hit, res_addr,
        output res_ready
    );
endinterface

// File: rtl/cam_result_fifo.sv
// cam_result_fifo
//   Synchronous first-word-fall-through FIFO for lookup results.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears contents)
//     push, din  : write request and data
//     pop        : read request (ignored when empty)
//     dout       : head entry, valid whenever empty is low
//     empty      : no entries
//     count      : number of stored entries (0..DEPTH)
//   A push on a full FIFO is accepted only together with a pop.
module cam_result_fifo #(
    parameter  int W     = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cam_access_ctrl.sv
// cam_access_ctrl
//   Front end of the CAM: arbitrates table updates against lookups, drives the
//   CAM write/compare ports, tracks compare latency and buffers results.
//   Ports:
//     CLK, RESETN     : clock, asynchronous active-low reset
//     bus (slave)     : upd_*, lkp_*, res_* channels (see cam_access_ctrl_if)
//     CAM_WE/ADDR_WR/DIN : CAM write port (WE is a single-cycle strobe)
//     CAM_BUSY        : CAM write in progress
//     CAM_CMP_DIN     : compare key, held until the next accepted key
//     CAM_MATCH/_ADDR : compare result, LOOKUP_LATENCY cycles after CMP_DIN
//     upd_count       : completed writes, wrapping 16-bit counter
//     fsm_state       : current controller state, for debug/observation
module cam_access_ctrl
    import cam_access_pkg::*;
#(
    parameter int C_TCAM_ADDR_WIDTH       = 5,
    parameter int C_TCAM_DATA_WIDTH       = 32,
    parameter int C_TCAM_MATCH_ADDR_WIDTH = 5,
    parameter int LOOKUP_LATENCY          = 1,
    parameter int RES_DEPTH               = 4
) (
    input  logic                               CLK,
    input  logic                               RESETN,
    cam_access_ctrl_if.slave                   bus,
    output logic                               CAM_WE,
    output logic [C_TCAM_ADDR_WIDTH-1:0]       CAM_ADDR_WR,
    output logic [C_TCAM_DATA_WIDTH-1:0]       CAM_DIN,
    input  logic                               CAM_BUSY,
    output logic [C_TCAM_DATA_WIDTH-1:0]       CAM_CMP_DIN,
    input  logic                               CAM_MATCH,
    input  logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] CAM_MATCH_ADDR,
    output logic [15:0]                        upd_count,
    output cam_state_e                         fsm_state
);
    localparam int REC_W = res_rec_width(C_TCAM_MATCH_ADDR_WIDTH);
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int IF_W  = $clog2(LOOKUP_LATENCY + 2);
    localparam int WCW   = $clog2(WAIT_MIN + 1);

    cam_state_e                 state, state_nxt;
    logic [WCW-1:0]             wait_cnt;
    logic                       wait_done;
    logic                       upd_ready_w;
    logic                       lkp_ready_w;
    logic                       lkp_hs;
    logic                       upd_hs;
    logic                       cmp_vld;
    logic [LOOKUP_LATENCY-1:0]  lat_pipe;
    logic [IF_W-1:0]            inflight;
    logic [CNT_W-1:0]           fifo_count;
    logic [CNT_W:0]             occupancy;
    logic                       credit_ok;
    logic                       fifo_empty;
    logic [REC_W-1:0]           push_rec;
    logic [REC_W-1:0]           pop_rec;

    // Keys in flight: the one just registered onto CMP_DIN plus those walking
    // through the CAM latency pipe. Each of them owns a FIFO slot already.
    always_comb begin
        inflight = IF_W'(cmp_vld);
        for (int i = 0; i < LOOKUP_LATENCY; i++) inflight = inflight + IF_W'(lat_pipe[i]);
    end

    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign credit_ok = occupancy < (CNT_W + 1)'(RES_DEPTH);
    assign wait_done = (wait_cnt >= WCW'(WAIT_MIN - 1));

    always_comb begin
        state_nxt   = state;
        upd_ready_w = 1'b0;
        lkp_ready_w = 1'b0;
        CAM_WE      = 1'b0;
        case (state)
            ST_IDLE: begin
                // RESETN term keeps lookups refused while reset is held.
                lkp_ready_w = RESETN && !bus.upd_valid && !CAM_BUSY && credit_ok;
                if (bus.upd_valid) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                upd_ready_w = (inflight == '0) && !CAM_BUSY;
                if (bus.upd_valid && upd_ready_w) state_nxt = ST_WRITE;
                else if (!bus.upd_valid)          state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                CAM_WE    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done && !CAM_BUSY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign upd_hs        = bus.upd_valid && upd_ready_w;
    assign lkp_hs        = bus.lkp_valid && lkp_ready_w;
    assign bus.upd_ready = upd_ready_w;
    assign bus.lkp_ready = lkp_ready_w;
    assign fsm_state     = state;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            upd_count   <= '0;
            CAM_ADDR_WR <= '0;
            CAM_DIN     <= '0;
            CAM_CMP_DIN <= '0;
            cmp_vld     <= 1'b0;
            lat_pipe    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WRITE)                 wait_cnt <= '0;
            else if (state == ST_WAIT && !wait_done) wait_cnt <= wait_cnt + 1'b1;
            if (state == ST_WAIT && state_nxt == ST_IDLE) upd_count <= upd_count + 16'd1;
            if (upd_hs) begin
                CAM_ADDR_WR <= bus.upd_addr;
                CAM_DIN     <= bus.upd_data;
            end
            if (lkp_hs) CAM_CMP_DIN <= bus.lkp_key;
            cmp_vld     <= lkp_hs;
            lat_pipe[0] <= cmp_vld;
            for (int i = 1; i < LOOKUP_LATENCY; i++) lat_pipe[i] <= lat_pipe[i-1];
        end
    end

    // Misses are recorded with a zero address regardless of CAM_MATCH_ADDR.
    assign push_rec = {CAM_MATCH, CAM_MATCH ? CAM_MATCH_ADDR : {C_TCAM_MATCH_ADDR_WIDTH{1'b0}}};

    cam_result_fifo #(
        .W     (REC_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (CLK),
        .rst_n (RESETN),
        .push  (lat_pipe[LOOKUP_LATENCY-1]),
        .din   (push_rec),
        .pop   (bus.res_valid && bus.res_ready),
        .dout  (pop_rec),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.res_valid = !fifo_empty;
    assign bus.res_hit   = pop_rec[REC_W-1];
    assign bus.res_addr  = pop_rec[REC_W-2:0];
endmodule
